multi_dataflow_ctrl_fsm: RTL and testbench



---
 rtl/multi_dataflow_ctrl_fsm.sv | 199 +++++++++++++++++++
 tb/tb_multi_dataflow_ctrl_fsm.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_ctrl_fsm.sv
// Control FSM for the multi_dataflow engine: sequences N_IN sources and N_OUT sinks
// through a multi-iteration job, counts per-sink output beats and flags job completion.
module multi_dataflow_ctrl_fsm #(
    parameter int  N_IN    = 1,
    parameter int  N_OUT   = 1,
    parameter int  CNT_LEN = 1024,
    parameter int  ITER_W  = 16,
    localparam int CNT_W   = $clog2(CNT_LEN) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [ITER_W-1:0]        nb_iter_i,
    input  logic [N_IN-1:0]          src_en_i,
    input  logic [N_OUT-1:0]         sink_en_i,
    input  logic [N_OUT*CNT_W-1:0]   cnt_limit_i,
    input  logic [N_IN-1:0]          src_ready_i,
    input  logic [N_IN-1:0]          src_done_i,
    input  logic [N_OUT-1:0]         sink_ready_i,
    input  logic [N_OUT-1:0]         sink_done_i,
    input  logic [N_OUT-1:0]         out_hs_i,
    input  logic                     kernel_done_i,
    output logic [N_IN-1:0]          src_start_o,
    output logic [N_OUT-1:0]         sink_start_o,
    output logic                     kernel_start_o,
    output logic                     engine_clear_o,
    output logic                     engine_enable_o,
    output logic [N_OUT*CNT_W-1:0]   cnt_o,
    output logic [ITER_W-1:0]        iter_idx_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        COMPUTE   = 3'd2,
        WAIT      = 3'd3,
        UPDATEIDX = 3'd4,
        TERMINATE = 3'd5
    } state_e;

    state_e                        state_q, state_d;
    logic [ITER_W-1:0]             iter_idx_q, iter_idx_d;
    logic [ITER_W-1:0]             nb_iter_q, nb_iter_d;
    logic [N_IN-1:0]               src_en_q, src_en_d;
    logic [N_OUT-1:0]              sink_en_q, sink_en_d;
    logic [N_OUT-1:0][CNT_W-1:0]   limit_q, limit_d;
    logic [N_OUT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                          kdone_q, kdone_d;
    logic [N_IN-1:0]               src_done_q, src_done_d;
    logic [N_OUT-1:0]              sink_done_q, sink_done_d;

    logic                          src_ready_ok, sink_ready_ok;
    logic                          src_done_ok, sink_done_ok;
    logic                          fire;
    logic [N_OUT-1:0]              sink_cmp;
    logic [ITER_W-1:0]             iter_inc;

    always_comb begin
        src_ready_ok  = &(src_ready_i | ~src_en_q);
        sink_ready_ok = &(sink_ready_i | ~sink_en_q);
        src_done_ok   = &(src_done_q | ~src_en_q);
        sink_done_ok  = &(sink_done_q | ~sink_en_q);
        fire          = (state_q == START) && src_ready_ok && sink_ready_ok && !clear_i;
        iter_inc      = iter_idx_q + ITER_W'(1);
        for (int k = 0; k < N_OUT; k++) begin
            sink_cmp[k] = ~sink_en_q[k] | (cnt_q[k] == limit_q[k]);
        end

        state_d     = state_q;
        iter_idx_d  = iter_idx_q;
        nb_iter_d   = nb_iter_q;
        src_en_d    = src_en_q;
        sink_en_d   = sink_en_q;
        limit_d     = limit_q;
        cnt_d       = cnt_q;
        kdone_d     = kdone_q;
        src_done_d  = src_done_q;
        sink_done_d = sink_done_q;

        // Done flags are sticky from START onward so early pulses are never lost
        if (state_q inside {START, COMPUTE, WAIT}) begin
            src_done_d  = src_done_q | src_done_i;
            sink_done_d = sink_done_q | sink_done_i;
        end
        if (state_q inside {START, COMPUTE}) begin
            kdone_d = kdone_q | kernel_done_i;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nb_iter_d   = (nb_iter_i == '0) ? ITER_W'(1) : nb_iter_i;
                    src_en_d    = src_en_i;
                    sink_en_d   = sink_en_i;
                    limit_d     = cnt_limit_i;
                    iter_idx_d  = '0;
                    kdone_d     = 1'b0;
                    src_done_d  = '0;
                    sink_done_d = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (fire) begin
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (out_hs_i[k] && sink_en_q[k] && (cnt_q[k] < limit_q[k])) begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                if ((&sink_cmp) && kdone_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (src_done_ok && sink_done_ok) begin
                    state_d = UPDATEIDX;
                end
            end
            UPDATEIDX: begin
                if (iter_inc == nb_iter_q) begin
                    state_d = TERMINATE;
                end else begin
                    iter_idx_d  = iter_inc;
                    kdone_d     = 1'b0;
                    src_done_d  = '0;
                    sink_done_d = '0;
                    state_d     = START;
                end
            end
            TERMINATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d     = IDLE;
            iter_idx_d  = '0;
            nb_iter_d   = '0;
            src_en_d    = '0;
            sink_en_d   = '0;
            limit_d     = '0;
            cnt_d       = '0;
            kdone_d     = 1'b0;
            src_done_d  = '0;
            sink_done_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            iter_idx_q  <= '0;
            nb_iter_q   <= '0;
            src_en_q    <= '0;
            sink_en_q   <= '0;
            limit_q     <= '0;
            cnt_q       <= '0;
            kdone_q     <= 1'b0;
            src_done_q  <= '0;
            sink_done_q <= '0;
        end else begin
            state_q     <= state_d;
            iter_idx_q  <= iter_idx_d;
            nb_iter_q   <= nb_iter_d;
            src_en_q    <= src_en_d;
            sink_en_q   <= sink_en_d;
            limit_q     <= limit_d;
            cnt_q       <= cnt_d;
            kdone_q     <= kdone_d;
            src_done_q  <= src_done_d;
            sink_done_q <= sink_done_d;
        end
    end

    // Start pulses are Mealy on the ready handshake so they coincide with the cycle readies are seen
    assign src_start_o     = fire ? src_en_q : '0;
    assign sink_start_o    = fire ? sink_en_q : '0;
    assign kernel_start_o  = fire;
    assign engine_clear_o  = fire;
    assign engine_enable_o = (state_q == COMPUTE) || (state_q == WAIT);
    assign cnt_o           = cnt_q;
    assign iter_idx_o      = iter_idx_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == TERMINATE);
    assign state_o         = state_q;

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Directed bench for multi_dataflow_ctrl_fsm: 2 sources, 3 sinks, 5-bit beat counters,
// exercising saturation, masking, multi-iteration jobs, ready stalls and soft clear.
module tb_multi_dataflow_ctrl_fsm;

    localparam int N_IN    = 2;
    localparam int N_OUT   = 3;
    localparam int CNT_LEN = 16;
    localparam int ITER_W  = 8;
    localparam int CNT_W   = 5;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   clear_i;
    logic                   start_i;
    logic [ITER_W-1:0]      nb_iter_i;
    logic [N_IN-1:0]        src_en_i;
    logic [N_OUT-1:0]       sink_en_i;
    logic [N_OUT*CNT_W-1:0] cnt_limit_i;
    logic [N_IN-1:0]        src_ready_i;
    logic [N_IN-1:0]        src_done_i;
    logic [N_OUT-1:0]       sink_ready_i;
    logic [N_OUT-1:0]       sink_done_i;
    logic [N_OUT-1:0]       out_hs_i;
    logic                   kernel_done_i;
    logic [N_IN-1:0]        src_start_o;
    logic [N_OUT-1:0]       sink_start_o;
    logic                   kernel_start_o;
    logic                   engine_clear_o;
    logic                   engine_enable_o;
    logic [N_OUT*CNT_W-1:0] cnt_o;
    logic [ITER_W-1:0]      iter_idx_o;
    logic                   busy_o;
    logic                   done_o;
    logic [2:0]             state_o;

    int tests_run        = 0;
    int fail_count       = 0;
    int done_seen        = 0;
    int kstart_seen      = 0;
    int sink2_start_seen = 0;

    logic [N_IN-1:0]  src_en_cfg;
    logic [N_OUT-1:0] sink_en_cfg;
    int               lim [3];

    multi_dataflow_ctrl_fsm #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .CNT_LEN(CNT_LEN),
        .ITER_W (ITER_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .nb_iter_i      (nb_iter_i),
        .src_en_i       (src_en_i),
        .sink_en_i      (sink_en_i),
        .cnt_limit_i    (cnt_limit_i),
        .src_ready_i    (src_ready_i),
        .src_done_i     (src_done_i),
        .sink_ready_i   (sink_ready_i),
        .sink_done_i    (sink_done_i),
        .out_hs_i       (out_hs_i),
        .kernel_done_i  (kernel_done_i),
        .src_start_o    (src_start_o),
        .sink_start_o   (sink_start_o),
        .kernel_start_o (kernel_start_o),
        .engine_clear_o (engine_clear_o),
        .engine_enable_o(engine_enable_o),
        .cnt_o          (cnt_o),
        .iter_idx_o     (iter_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters sampled mid-cycle so each one-cycle pulse counts exactly once
    always @(negedge clk_i) begin
        if (done_o) done_seen++;
        if (kernel_start_o) kstart_seen++;
        if (sink_start_o[2]) sink2_start_seen++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ITER_W-1:0] nb, input logic [N_IN-1:0] sen,
                                 input logic [N_OUT-1:0] ken, input int l0, input int l1, input int l2);
        src_en_cfg  = sen;
        sink_en_cfg = ken;
        lim         = '{l0, l1, l2};
        nb_iter_i   = nb;
        src_en_i    = sen;
        sink_en_i   = ken;
        cnt_limit_i = {CNT_W'(l2), CNT_W'(l1), CNT_W'(l0)};
        start_i     = 1'b1;
        step();
        // Scrambled inputs must not disturb the latched job configuration
        start_i     = 1'b0;
        nb_iter_i   = nb + 8'd1;
        src_en_i    = ~sen;
        sink_en_i   = ~ken;
        cnt_limit_i = '1;
    endtask

    task automatic run_iteration(input int idx, input int b0, input int b1, input int b2, input bit last);
        int                     bt [3];
        int                     nb;
        logic [N_OUT*CNT_W-1:0] exp_cnt;
        bt = '{b0, b1, b2};
        nb = 1;
        for (int k = 0; k < 3; k++) if (bt[k] > nb) nb = bt[k];
        exp_cnt = '0;
        for (int k = 0; k < 3; k++) begin
            if (sink_en_cfg[k]) exp_cnt[k*CNT_W +: CNT_W] = CNT_W'((bt[k] < lim[k]) ? bt[k] : lim[k]);
        end
        #1;
        checkOutput("start_state", state_o, 1);
        checkOutput("start_iter_idx", iter_idx_o, idx);
        checkOutput("src_start", src_start_o, src_en_cfg);
        checkOutput("sink_start", sink_start_o, sink_en_cfg);
        checkOutput("kernel_start", kernel_start_o, 1);
        checkOutput("engine_clear", engine_clear_o, 1);
        step();
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 3; k++) out_hs_i[k] = (b < bt[k]);
            kernel_done_i = (b == nb - 1);
            if (b == 0) begin
                #1;
                checkOutput("compute_state", state_o, 2);
                checkOutput("engine_enable", engine_enable_o, 1);
                checkOutput("no_restart", kernel_start_o, 0);
            end
            step();
        end
        out_hs_i      = '0;
        kernel_done_i = 1'b0;
        #1;
        checkOutput("cnt", cnt_o, exp_cnt);
        checkOutput("compute_last", state_o, 2);
        step();
        src_done_i  = src_en_cfg;
        sink_done_i = sink_en_cfg;
        #1;
        checkOutput("wait_state", state_o, 3);
        step();
        src_done_i  = '0;
        sink_done_i = '0;
        #1;
        checkOutput("wait_hold", state_o, 3);
        step();
        #1;
        checkOutput("updateidx_state", state_o, 4);
        step();
        if (last) begin
            #1;
            checkOutput("terminate_state", state_o, 5);
            checkOutput("done_pulse", done_o, 1);
            checkOutput("term_iter_idx", iter_idx_o, idx);
            step();
            #1;
            checkOutput("idle_state", state_o, 0);
            checkOutput("idle_busy", busy_o, 0);
            checkOutput("idle_done", done_o, 0);
            checkOutput("cnt_hold", cnt_o, exp_cnt);
            checkOutput("iter_hold", iter_idx_o, idx);
        end
    endtask

    initial begin
        int ks0;
        int dn0;
        int s20;
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        start_i       = 1'b0;
        nb_iter_i     = '0;
        src_en_i      = '0;
        sink_en_i     = '0;
        cnt_limit_i   = '0;
        src_ready_i   = '0;
        src_done_i    = '0;
        sink_ready_i  = '0;
        sink_done_i   = '0;
        out_hs_i      = '0;
        kernel_done_i = 1'b0;
        src_en_cfg    = '0;
        sink_en_cfg   = '0;
        lim           = '{0, 0, 0};

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_cnt", cnt_o, 0);
        checkOutput("rst_iter", iter_idx_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_starts", {src_start_o, sink_start_o, kernel_start_o, engine_clear_o}, 0);
        rst_ni       = 1'b1;
        src_ready_i  = 2'b11;
        sink_ready_i = 3'b111;
        step();

        // Single stream, limit 4, seven beats: counter saturates
        ks0 = kstart_seen; dn0 = done_seen;
        applyStimulus(8'd1, 2'b01, 3'b001, 4, 0, 0);
        run_iteration(0, 7, 0, 0, 1'b1);
        checkOutput("t1_kstart_count", kstart_seen - ks0, 1);
        checkOutput("t1_done_count", done_seen - dn0, 1);

        // Three iterations, sink 2 disabled with limit 0
        ks0 = kstart_seen; dn0 = done_seen; s20 = sink2_start_seen;
        applyStimulus(8'd3, 2'b11, 3'b011, 3, 5, 0);
        run_iteration(0, 3, 5, 0, 1'b0);
        run_iteration(1, 4, 6, 0, 1'b0);
        run_iteration(2, 3, 5, 0, 1'b1);
        checkOutput("t2_kstart_count", kstart_seen - ks0, 3);
        checkOutput("t2_done_count", done_seen - dn0, 1);
        checkOutput("t2_sink2_never", sink2_start_seen - s20, 0);

        // Sink 0 not ready for 10 cycles; nb_iter 0; early kernel/stream done pulses in START
        ks0 = kstart_seen; dn0 = done_seen;
        sink_ready_i = 3'b110;
        applyStimulus(8'd0, 2'b01, 3'b001, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            kernel_done_i = (c == 2);
            src_done_i    = (c == 4) ? 2'b01 : 2'b00;
            sink_done_i   = (c == 4) ? 3'b001 : 3'b000;
            #1;
            checkOutput("stall_no_start", {src_start_o, sink_start_o, kernel_start_o, engine_clear_o}, 0);
            checkOutput("stall_state", state_o, 1);
            step();
        end
        kernel_done_i = 1'b0;
        src_done_i    = '0;
        sink_done_i   = '0;
        sink_ready_i  = 3'b111;
        #1;
        checkOutput("stall_release", {src_start_o, sink_start_o, kernel_start_o, engine_clear_o}, 7'b01_001_1_1);
        step(); #1;
        checkOutput("t4_compute", state_o, 2);
        step(); #1;
        checkOutput("t4_wait", state_o, 3);
        step(); #1;
        checkOutput("t4_update", state_o, 4);
        step(); #1;
        checkOutput("t4_terminate", state_o, 5);
        checkOutput("t4_done", done_o, 1);
        step(); #1;
        checkOutput("t4_idle", state_o, 0);
        checkOutput("t4_kstart_count", kstart_seen - ks0, 1);
        checkOutput("t4_done_count", done_seen - dn0, 1);

        // Soft clear in the second iteration's COMPUTE with cnt=2, then a clean rerun
        dn0 = done_seen;
        applyStimulus(8'd2, 2'b01, 3'b001, 4, 0, 0);
        run_iteration(0, 4, 0, 0, 1'b0);
        #1;
        checkOutput("t5_iter1", iter_idx_o, 1);
        step();
        out_hs_i = 3'b001;
        step();
        step();
        out_hs_i = 3'b000;
        #1;
        checkOutput("t5_cnt_pre_clear", cnt_o, 2);
        clear_i       = 1'b1;
        out_hs_i      = 3'b001;
        kernel_done_i = 1'b1;
        step();
        clear_i       = 1'b0;
        out_hs_i      = 3'b000;
        kernel_done_i = 1'b0;
        #1;
        checkOutput("clr_state", state_o, 0);
        checkOutput("clr_cnt", cnt_o, 0);
        checkOutput("clr_iter", iter_idx_o, 0);
        checkOutput("clr_busy", busy_o, 0);
        checkOutput("clr_enable", engine_enable_o, 0);
        repeat (3) step();
        checkOutput("clr_no_done", done_seen - dn0, 0);
        applyStimulus(8'd1, 2'b01, 3'b001, 4, 0, 0);
        run_iteration(0, 5, 0, 0, 1'b1);
        checkOutput("t5_done_count", done_seen - dn0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
